// File: rtl/jt1942_sdram_arb_if.sv
// rtl/jt1942_sdram_arb_if.sv - SDRAM read/refresh bus between the ROM arbiter and the SDRAM controller
interface jt1942_sdram_arb_if;
    logic        sdram_re;
    logic [21:0] sdram_addr;
    logic        autorefresh;
    logic [15:0] data_read;

    modport master (
        output sdram_re,
        output sdram_addr,
        output autorefresh,
        input  data_read
    );

    modport slave (
        input  sdram_re,
        input  sdram_addr,
        input  autorefresh,
        output data_read
    );
endinterface

// File: rtl/jt1942_sdram_arb.sv
// rtl/jt1942_sdram_arb.sv - four-slot cached SDRAM read scheduler with vblank refresh (option: JT1942_ARB_FIXPRIO_EN)
module jt1942_sdram_arb #(
    parameter int RD_LAT  = 4,
    parameter int REF_LAT = 6,
    parameter int REF_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic        LVBL,
    input  logic [21:0] addr0,
    input  logic [21:0] addr1,
    input  logic [21:0] addr2,
    input  logic [21:0] addr3,
    input  logic [3:0]  cs,
    output logic [15:0] dout0,
    output logic [15:0] dout1,
    output logic [15:0] dout2,
    output logic [15:0] dout3,
    output logic [3:0]  ok,
    jt1942_sdram_arb_if.master sdram
);

    localparam int CW = $clog2(REF_MAX + 2);

    typedef enum logic [1:0] {IDLE, WAIT, REF} state_t;

    state_t        state, state_nx;
    logic [21:0]   addr_a [4];
    logic [21:0]   tag    [4];
    logic [15:0]   data   [4];
    logic [3:0]    valid;
    logic [3:0]    pending;
    logic [3:0]    cnt;
    logic [1:0]    gnt;
    logic [1:0]    sel;
    logic [1:0]    idx;
    logic [1:0]    start;
    logic          found;
    logic [CW-1:0] ref_cnt;
    logic          lvbl_l;
    logic          take_gnt;
    logic          take_ref;
    logic          capture;
    logic          ref_end;
`ifndef JT1942_ARB_FIXPRIO_EN
    logic [1:0]    rr;
`endif

    assign addr_a[0] = addr0;
    assign addr_a[1] = addr1;
    assign addr_a[2] = addr2;
    assign addr_a[3] = addr3;

    assign dout0 = data[0];
    assign dout1 = data[1];
    assign dout2 = data[2];
    assign dout3 = data[3];

    // A slot hits when its cached tag is valid and matches the live address
    always_comb begin
        pending = '0;
        ok      = '0;
        for (int i = 0; i < 4; i++) begin
            pending[i] = cs[i] & (~valid[i] | (addr_a[i] != tag[i]));
            ok[i]      = cs[i] & valid[i] & (addr_a[i] == tag[i]);
        end
    end

`ifdef JT1942_ARB_FIXPRIO_EN
    assign start = 2'd0;
`else
    assign start = rr;
`endif

    // First pending slot, scanning upward from the search start and wrapping
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && pending[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode; reads win over refresh, nothing starts while downloading
    always_comb begin
        state_nx = state;
        take_gnt = 1'b0;
        take_ref = 1'b0;
        capture  = 1'b0;
        ref_end  = 1'b0;
        case (state)
            IDLE: begin
                if (!downloading) begin
                    if (found) begin
                        take_gnt = 1'b1;
                        state_nx = WAIT;
                    end else if (!LVBL && ref_cnt < CW'(REF_MAX)) begin
                        take_ref = 1'b1;
                        state_nx = REF;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    capture  = 1'b1;
                    state_nx = IDLE;
                end
            end
            REF: begin
                // Ending on the count of one keeps autorefresh high for exactly REF_LAT cycles
                if (cnt <= 4'd1) begin
                    ref_end  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Tags, cached words, bus outputs, counters and refresh bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdram.sdram_re    <= 1'b0;
            sdram.sdram_addr  <= '0;
            sdram.autorefresh <= 1'b0;
            cnt               <= '0;
            gnt               <= '0;
            valid             <= '0;
            ref_cnt           <= '0;
            lvbl_l            <= 1'b1;
`ifndef JT1942_ARB_FIXPRIO_EN
            rr                <= '0;
`endif
            for (int i = 0; i < 4; i++) begin
                tag[i]  <= '0;
                data[i] <= '0;
            end
        end else begin
            sdram.sdram_re <= take_gnt;
            lvbl_l         <= LVBL;
            if (state == IDLE && downloading) valid <= '0;
            if (state != IDLE && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (take_gnt) begin
                // The tag is not trusted until its data has been captured
                tag[sel]         <= addr_a[sel];
                valid[sel]       <= 1'b0;
                gnt              <= sel;
                sdram.sdram_addr <= addr_a[sel];
                cnt              <= 4'(RD_LAT);
            end
            if (take_ref) begin
                sdram.autorefresh <= 1'b1;
                cnt               <= 4'(REF_LAT);
            end
            if (capture) begin
                data[gnt]  <= sdram.data_read;
                valid[gnt] <= 1'b1;
`ifndef JT1942_ARB_FIXPRIO_EN
                rr         <= gnt + 2'd1;
`endif
            end
            if (ref_end) sdram.autorefresh <= 1'b0;
            if (LVBL && !lvbl_l)  ref_cnt <= '0;
            else if (take_ref)    ref_cnt <= ref_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_jt1942_sdram_arb.sv
// tb/tb_jt1942_sdram_arb.sv - randomized self-checking bench for jt1942_sdram_arb
module tb_jt1942_sdram_arb;
    localparam int RD_LAT  = 4;
    localparam int REF_LAT = 6;
    localparam int REF_MAX = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        downloading;
    logic        LVBL;
    logic [21:0] a [4];
    logic [3:0]  cs;
    logic [15:0] d [4];
    logic [3:0]  ok;
    int          errors = 0;
    int          checks = 0;

    jt1942_sdram_arb_if sd();

    function automatic logic [15:0] mem_word(input logic [21:0] x);
        return x[15:0] ^ 16'hBFEF ^ {10'd0, x[21:16]};
    endfunction

    assign sd.data_read = mem_word(sd.sdram_addr);

    jt1942_sdram_arb #(.RD_LAT(RD_LAT), .REF_LAT(REF_LAT), .REF_MAX(REF_MAX)) dut (
        .clk(clk), .rst(rst), .downloading(downloading), .LVBL(LVBL),
        .addr0(a[0]), .addr1(a[1]), .addr2(a[2]), .addr3(a[3]), .cs(cs),
        .dout0(d[0]), .dout1(d[1]), .dout2(d[2]), .dout3(d[3]), .ok(ok),
        .sdram(sd)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; downloading = 1'b0; LVBL = 1'b1; cs = 4'd0;
        for (int i = 0; i < 4; i++) a[i] = '0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; downloading = 1'b0; LVBL = 1'b1; cs = 4'hF;
        for (int i = 0; i < 4; i++) a[i] = 22'h00010 + 22'(i);
        step(); step();
        checks++; if (ok !== 4'd0) begin errors++; $display("FAIL reset_ok got=%h exp=0", ok); end
        checks++; if (sd.sdram_re !== 1'b0) begin errors++; $display("FAIL reset_re got=%b exp=0", sd.sdram_re); end
        checks++; if (sd.autorefresh !== 1'b0) begin errors++; $display("FAIL reset_ar got=%b exp=0", sd.autorefresh); end
        checks++; if (sd.sdram_addr !== 22'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", sd.sdram_addr); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (d[i] !== 16'd0) begin errors++; $display("FAIL reset_dout%0d got=%h exp=0", i, d[i]); end
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int n;
        do_reset();
        a[0] = 22'h0002A; cs = 4'b0001;
        step();
        checks++; if (sd.sdram_re !== 1'b1) begin errors++; $display("FAIL rmw_grant got=%b exp=1", sd.sdram_re); end
        step(); step();
        rst = 1'b1; cs = 4'd0;
        #1;
        checks++; if (ok !== 4'd0 || sd.sdram_re !== 1'b0) begin errors++; $display("FAIL rmw_async ok=%h re=%b exp 0/0", ok, sd.sdram_re); end
        step();
        rst = 1'b0;
        n = 0;
        repeat (15) begin
            step();
            if (sd.sdram_re || ok != 4'd0 || sd.autorefresh) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL rmw_quiet got=%0d exp=0", n); end
        checks++; if (d[0] !== 16'd0) begin errors++; $display("FAIL rmw_nocapture got=%h exp=0", d[0]); end
    endtask

    task automatic test_single_read();
        int n_re, lat;
        logic [21:0] re_addr;
        do_reset();
        n_re = 0; lat = -1; re_addr = '0;
        a[0] = 22'h00100; cs = 4'b0001;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (sd.sdram_re) begin n_re++; re_addr = sd.sdram_addr; end
            if (ok[0] && lat < 0) lat = c;
        end
        checks++; if (lat !== RD_LAT + 2) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", lat, RD_LAT + 2); end
        checks++; if (n_re !== 1) begin errors++; $display("FAIL single_re_count got=%0d exp=1", n_re); end
        checks++; if (re_addr !== 22'h00100) begin errors++; $display("FAIL single_addr got=%h exp=00100", re_addr); end
        checks++; if (d[0] !== 16'hBEEF) begin errors++; $display("FAIL single_dout got=%h exp=beef", d[0]); end
        checks++; if (ok !== 4'b0001) begin errors++; $display("FAIL single_ok got=%b exp=0001", ok); end
    endtask

    task automatic test_round_robin();
        int order[$];
        do_reset();
        a[0] = 22'h000A0; a[1] = 22'h0B0B1; a[2] = 22'h1C0C2; a[3] = 22'h2D0D3;
        cs = 4'hF;
        for (int c = 0; c < 60; c++) begin
            step();
            if (sd.sdram_re)
                for (int j = 0; j < 4; j++) if (sd.sdram_addr == a[j]) order.push_back(j);
        end
        checks++; if (order.size() !== 4) begin errors++; $display("FAIL rr_count got=%0d exp=4", order.size()); end
        for (int k = 0; k < order.size() && k < 4; k++) begin
            checks++; if (order[k] !== k) begin errors++; $display("FAIL rr_order%0d got=%0d exp=%0d", k, order[k], k); end
        end
        checks++; if (ok !== 4'hF) begin errors++; $display("FAIL rr_ok got=%b exp=1111", ok); end
        for (int j = 0; j < 4; j++) begin
            checks++; if (d[j] !== mem_word(a[j])) begin errors++; $display("FAIL rr_dout%0d got=%h exp=%h", j, d[j], mem_word(a[j])); end
        end
`ifdef JT1942_ARB_FIXPRIO_EN
        begin
            int g0, other;
            do_reset();
            g0 = 0; other = 0;
            a[0] = 22'h00200; a[1] = 22'h01201; a[2] = 22'h02202; a[3] = 22'h03203;
            cs = 4'hF;
            for (int c = 0; c < 60; c++) begin
                step();
                if (sd.sdram_re) begin
                    if (sd.sdram_addr == a[0]) g0++;
                    else other++;
                end
                if (ok[0]) a[0] = a[0] + 22'd1;
            end
            checks++; if (other !== 0) begin errors++; $display("FAIL prio_other got=%0d exp=0", other); end
            checks++; if (g0 < 5) begin errors++; $display("FAIL prio_slot0 got=%0d exp>=5", g0); end
            checks++; if (ok[3] !== 1'b0) begin errors++; $display("FAIL prio_slot3_wait got=%b exp=0", ok[3]); end
        end
`endif
    endtask

    task automatic test_refresh();
        int pulses, width, bad, re_seen;
        logic prev, fell, seen;
        do_reset();
        pulses = 0; width = 0; bad = 0; re_seen = 0; prev = 1'b0;
        LVBL = 1'b0;
        for (int c = 0; c < 150; c++) begin
            step();
            if (sd.sdram_re) re_seen++;
            if (sd.autorefresh) width++;
            if (sd.autorefresh && !prev) pulses++;
            if (!sd.autorefresh && prev) begin
                if (width != REF_LAT) bad++;
                width = 0;
            end
            prev = sd.autorefresh;
        end
        checks++; if (pulses !== REF_MAX) begin errors++; $display("FAIL ref_pulses got=%0d exp=%0d", pulses, REF_MAX); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL ref_width bad_pulses=%0d exp=0", bad); end
        checks++; if (re_seen !== 0) begin errors++; $display("FAIL ref_no_read got=%0d exp=0", re_seen); end
        LVBL = 1'b1; step(); step();
        LVBL = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (sd.autorefresh) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL ref_restart got=%b exp=1", seen); end
        step(); step();
        a[2] = 22'h03333; cs = 4'b0100;
        fell = 1'b0;
        for (int c = 0; c < 20 && !fell; c++) begin
            prev = sd.autorefresh;
            step();
            if (prev && !sd.autorefresh) begin
                fell = 1'b1;
                checks++; if (sd.sdram_re !== 1'b0) begin errors++; $display("FAIL ref_fall_re got=%b exp=0", sd.sdram_re); end
                step();
                checks++; if (sd.sdram_re !== 1'b1 || sd.sdram_addr !== 22'h03333) begin
                    errors++; $display("FAIL ref_then_grant re=%b addr=%h exp 1/03333", sd.sdram_re, sd.sdram_addr);
                end
            end
        end
        checks++; if (fell !== 1'b1) begin errors++; $display("FAIL ref_end_timeout got=%b exp=1", fell); end
    endtask

    task automatic test_addr_change_wait();
        int n2;
        logic early;
        logic [21:0] addr2nd;
        do_reset();
        a[1] = 22'h05555; cs = 4'b0010;
        step();
        checks++; if (sd.sdram_re !== 1'b1 || sd.sdram_addr !== 22'h05555) begin
            errors++; $display("FAIL acw_first re=%b addr=%h exp 1/05555", sd.sdram_re, sd.sdram_addr);
        end
        step();
        a[1] = 22'h06666;
        n2 = 0; early = 1'b0; addr2nd = '0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (sd.sdram_re) begin n2++; addr2nd = sd.sdram_addr; end
            if (ok[1] && n2 == 0) early = 1'b1;
        end
        checks++; if (n2 !== 1) begin errors++; $display("FAIL acw_reissue got=%0d exp=1", n2); end
        checks++; if (addr2nd !== 22'h06666) begin errors++; $display("FAIL acw_addr got=%h exp=06666", addr2nd); end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL acw_stale_ok got=%b exp=0", early); end
        checks++; if (ok[1] !== 1'b1 || d[1] !== mem_word(22'h06666)) begin
            errors++; $display("FAIL acw_final ok=%b dout=%h exp 1/%h", ok[1], d[1], mem_word(22'h06666));
        end
    endtask

    task automatic test_download();
        int bad, n;
        do_reset();
        for (int i = 0; i < 4; i++) a[i] = 22'h10000 + 22'(i * 37);
        cs = 4'hF; LVBL = 1'b0;
        repeat (40) step();
        downloading = 1'b1;
        repeat (12) step();
        bad = 0;
        repeat (30) begin
            step();
            if (sd.sdram_re || sd.autorefresh || ok != 4'd0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL dl_frozen got=%0d exp=0", bad); end
        checks++; if (ok !== 4'd0) begin errors++; $display("FAIL dl_ok got=%b exp=0000", ok); end
        downloading = 1'b0; LVBL = 1'b1;
        n = 0;
        repeat (40) begin
            step();
            if (sd.sdram_re) n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL dl_refetch got=%0d exp=4", n); end
        checks++; if (ok !== 4'hF) begin errors++; $display("FAIL dl_ok_after got=%b exp=1111", ok); end
    endtask

    task automatic test_random();
        logic [21:0] tag_m [4];
        logic [3:0]  valid_m, pend, ok_exp;
        logic [1:0]  rr_m;
        logic        prev_ar, dmis;
        int          gnt_m, cap_cnt, exp_s, st, idx, j;
        do_reset();
        for (int i = 0; i < 4; i++) tag_m[i] = '0;
        valid_m = '0; rr_m = '0; gnt_m = 0; cap_cnt = 0; prev_ar = 1'b0;
        for (int s = 0; s < 3000; s++) begin
            step();
            if (cap_cnt > 0) begin
                cap_cnt--;
                if (cap_cnt == 0) valid_m[gnt_m] = 1'b1;
            end
            for (int i = 0; i < 4; i++)
                pend[i] = cs[i] && (!valid_m[i] || a[i] != tag_m[i]);
            if (sd.sdram_re) begin
`ifdef JT1942_ARB_FIXPRIO_EN
                st = 0;
`else
                st = int'(rr_m);
`endif
                exp_s = -1;
                for (int k = 0; k < 4; k++) begin
                    idx = (st + k) % 4;
                    if (exp_s < 0 && pend[idx]) exp_s = idx;
                end
                checks++;
                if (exp_s < 0) begin
                    errors++; $display("FAIL rand_spurious_re addr=%h pending=%b", sd.sdram_addr, pend);
                end else if (sd.sdram_addr !== a[exp_s]) begin
                    errors++; $display("FAIL rand_grant got=%h exp=%h slot=%0d", sd.sdram_addr, a[exp_s], exp_s);
                end
                if (exp_s >= 0) begin
                    tag_m[exp_s] = a[exp_s]; valid_m[exp_s] = 1'b0;
                    gnt_m = exp_s; rr_m = 2'(exp_s + 1); cap_cnt = RD_LAT + 1;
                end
            end
            if (sd.autorefresh && !prev_ar) begin
                checks++;
                if (pend != 4'd0 || LVBL) begin
                    errors++; $display("FAIL rand_refresh_busy pending=%b lvbl=%b exp 0000/0", pend, LVBL);
                end
            end
            prev_ar = sd.autorefresh;
            dmis = 1'b0;
            for (int i = 0; i < 4; i++) begin
                ok_exp[i] = cs[i] & valid_m[i] & (a[i] == tag_m[i]);
                if (valid_m[i] && d[i] !== mem_word(tag_m[i])) dmis = 1'b1;
            end
            checks++;
            if (ok !== ok_exp || dmis) begin
                errors++; $display("FAIL rand_ok step=%0d got=%b exp=%b dout_bad=%b", s, ok, ok_exp, dmis);
            end
            if (s < 2800) begin
                for (int i = 0; i < 4; i++)
                    if ($urandom_range(0, 7) == 0) a[i] = 22'($urandom_range(0, 5)) | (22'(i) << 20);
                if ($urandom_range(0, 15) == 0) begin
                    j = $urandom_range(0, 3);
                    cs[j] = ~cs[j];
                end
                if (s % 150 == 0) LVBL = ~LVBL;
            end else begin
                cs = 4'hF; LVBL = 1'b1;
            end
        end
        checks++; if (ok !== 4'hF) begin errors++; $display("FAIL rand_settle got=%b exp=1111", ok); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_single_read();
        test_round_robin();
        test_refresh();
        test_addr_change_wait();
        test_download();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jt1942_sdram_arb.md
Name: jt1942_sdram_arb

Overview:
- Four-requester SDRAM read scheduler for the 1942 game core.
- Shares the single 16-bit SDRAM read path between main CPU, sound CPU, char and object ROM fetchers.
- Each requester sees a one-word cache: a new SDRAM read is issued only when its address changes.
- Inserts autorefresh cycles during vertical blank when the bus is idle. Sits between the game-level ROM clients and the SDRAM controller.

Parameters:
RD_LAT, 4, clk cycles from sdram_re to valid data_read (2..15)
REF_LAT, 6, clk cycles an autorefresh occupies the bus (2..15)
REF_MAX, 8, maximum refreshes issued per vertical blank

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
downloading  in  1  ROM load in progress; arbiter frozen
LVBL  in  1  vertical blank, active low
addr0  in  22  main CPU word address
addr1  in  22  sound CPU word address
addr2  in  22  char ROM word address
addr3  in  22  object ROM word address
cs  in  4  per-slot request enable; slot ignored while low
dout0..dout3  out  16 each  cached word for each slot
ok  out  4  slot data valid for its current address
sdram_re  out  1  one-cycle read strobe
sdram_addr  out  22  read address, held from sdram_re until data captured
autorefresh  out  1  high for whole refresh slot
data_read  in  16  SDRAM read data

Behaviour:
- Reset (async, rst high): state IDLE; ok=0; dout0..3=0; sdram_re=0; sdram_addr=0; autorefresh=0; rr pointer=0; refresh count=0; tag registers cleared and marked invalid.
- Per slot: tag register plus valid bit. Pending when cs[i]=1 and (addr_i != tag_i or valid_i=0).
- ok[i] is combinational: ok[i] = cs[i] & valid_i & (addr_i == tag_i). An address change drops ok in the same cycle.
- States:
  - IDLE. If downloading: stay, clear all valid bits.
    - Else if any slot pending: grant the first pending slot searching rr, rr+1, ... mod 4. Latch tag_i=addr_i, drive sdram_addr=addr_i, pulse sdram_re for 1 cycle, load counter=RD_LAT, go WAIT.
    - Else if LVBL=0 and refresh count < REF_MAX: autorefresh=1, counter=REF_LAT, count+1, go REF.
  - WAIT: decrement counter. At 0: dout_g <= data_read; valid_g <= 1; rr <= g+1 mod 4; go IDLE.
    - If addr_g changed during WAIT, the captured data is still written under the old tag, so ok stays low and the slot re-requests next IDLE.
  - REF: autorefresh held high; decrement; at 0 drop autorefresh, go IDLE.
- Refresh count clears on LVBL rising edge (registered edge detect).
- Read latency, ideal case: address change to ok high = RD_LAT+2 cycles (1 IDLE decision, RD_LAT wait, 1 capture).
- Worst-case wait for a slot: 3 other reads, or 1 refresh plus 3 reads, before its grant.
- Simultaneous events:
  - Pending request beats refresh.
  - downloading asserted in WAIT/REF: current operation completes, then IDLE freezes.
  - cs[i] dropped mid-WAIT: data still captured.
- Counters are 4-bit; RD_LAT/REF_LAT outside 2..15 are unsupported.

Optional Feature:
JT1942_ARB_FIXPRIO_EN
- Defined: rr pointer removed; strict priority slot0 > slot1 > slot2 > slot3. Main CPU latency is then bounded by one in-flight operation.
- Undefined: round-robin as above.

Test Plan:
- Reset mid-WAIT (rst pulsed at counter=2) -> ok=0, sdram_re=0, state IDLE same cycle; no capture afterwards.
- Slot0 addr=22'h00100, cs=4'b0001, RD_LAT=4, data_read=16'hBEEF at capture -> single sdram_re with sdram_addr=22'h00100; ok[0] high 6 cycles after addr change; dout0=16'hBEEF. Holding addr issues no further sdram_re.
- All four slots change address in the same cycle, rr=0 -> grants in order 0,1,2,3, one sdram_re each, 4 reads total. With JT1942_ARB_FIXPRIO_EN and slot0 re-changing after every capture -> slot0 is granted each time and slot3 waits.
- LVBL=0, no pending requests, REF_MAX=8 -> exactly 8 autorefresh pulses, each REF_LAT=6 cycles wide. A slot2 request arriving mid-refresh is granted the cycle after refresh ends.
- addr1 changes during its WAIT -> ok[1] stays 0 after capture; a second sdram_re is issued with the new address; ok[1] rises after that read.
- downloading=1 -> no sdram_re and no autorefresh; ok=0. After downloading falls, all cs slots re-fetch.
